// File: rtl/taxi_fare_ctrl_if.sv
// Trip-control bus between the taxi front panel / metre counter and the fare engine.
interface taxi_fare_ctrl_if;
  logic        start;
  logic        pause;
  logic        end_trip;
  logic        ack;
  logic        km_co;
  logic        sec_tick;
  logic        meter_en;
  logic        meter_clr;
  logic [13:0] fare;
  logic [10:0] km_cnt;
  logic [7:0]  wait_units;
  logic [1:0]  state;
  logic        trip_done;

  // Driver side: panel buttons, metre carry and second tick.
  modport master (
    output start, pause, end_trip, ack, km_co, sec_tick,
    input  meter_en, meter_clr, fare, km_cnt, wait_units, state, trip_done
  );

  // Fare engine side.
  modport slave (
    input  start, pause, end_trip, ack, km_co, sec_tick,
    output meter_en, meter_clr, fare, km_cnt, wait_units, state, trip_done
  );
endinterface

// File: rtl/taxi_fare_ctrl.sv
// Taxi trip controller and fare engine: sequences the metre counter and
// accumulates distance, waiting time and a saturating fare in 0.1 yuan units.
module taxi_fare_ctrl #(
  parameter int BASE_FARE   = 100,
  parameter int BASE_KM     = 3,
  parameter int PER_KM_FARE = 20,
  parameter int WAIT_UNIT   = 60,
  parameter int WAIT_FARE   = 10,
  parameter int MAX_FARE    = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  taxi_fare_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIRED  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam int              SEC_W    = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(WAIT_UNIT - 1);
  localparam logic [10:0]     KM_MAX   = 11'h7ff;
  localparam logic [7:0]      WU_MAX   = 8'hff;

  state_t           state_q,     state_nxt;
  logic [13:0]      fare_q,      fare_nxt;
  logic [10:0]      km_q,        km_nxt;
  logic [7:0]       wu_q,        wu_nxt;
  logic [SEC_W-1:0] sec_q,       sec_nxt;
  logic             meter_en_q,  meter_en_nxt;
  logic             meter_clr_q, meter_clr_nxt;
  logic             done_q,      done_nxt;

  // Adds with one guard bit and clamps at the fare ceiling.
  function automatic logic [13:0] fare_add(input logic [13:0] base, input logic [13:0] inc);
    logic [14:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return (sum > 15'(MAX_FARE)) ? 14'(MAX_FARE) : sum[13:0];
  endfunction

  // Next-state, counter and fare update for the current trip phase.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt     = state_q;
    fare_nxt      = fare_q;
    km_nxt        = km_q;
    wu_nxt        = wu_q;
    sec_nxt       = sec_q;
    meter_clr_nxt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt     = ST_HIRED;
          meter_clr_nxt = 1'b1;
          fare_nxt      = 14'(BASE_FARE);
          km_nxt        = '0;
          wu_nxt        = '0;
          sec_nxt       = '0;
        end
      end
      ST_HIRED: begin
        if (bus.km_co) begin
          if (km_q != KM_MAX) km_nxt = km_q + 11'd1;
          if (km_q >= 11'(BASE_KM)) fare_nxt = fare_add(fare_q, 14'(PER_KM_FARE));
        end
        if (bus.end_trip)   state_nxt = ST_SETTLE;
        else if (bus.pause) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sec_tick) begin
          if (sec_q == SEC_LAST) begin
            sec_nxt  = '0;
            if (wu_q != WU_MAX) wu_nxt = wu_q + 8'd1;
            fare_nxt = fare_add(fare_q, 14'(WAIT_FARE));
          end else begin
            sec_nxt = sec_q + 1'b1;
          end
        end
        if (bus.end_trip)   state_nxt = ST_SETTLE;
        else if (bus.start) state_nxt = ST_HIRED;
      end
      ST_SETTLE: begin
        if (bus.ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Registered from the next state so metre gating switches on the leaving edge.
    meter_en_nxt = (state_nxt == ST_HIRED);
    done_nxt     = (state_nxt == ST_SETTLE);
  end

  // State and output registers with synchronous reset; a reset abandons the trip.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fare_q      <= '0;
      km_q        <= '0;
      wu_q        <= '0;
      sec_q       <= '0;
      meter_en_q  <= 1'b0;
      meter_clr_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_nxt;
      fare_q      <= fare_nxt;
      km_q        <= km_nxt;
      wu_q        <= wu_nxt;
      sec_q       <= sec_nxt;
      meter_en_q  <= meter_en_nxt;
      meter_clr_q <= meter_clr_nxt;
      done_q      <= done_nxt;
    end
  end

  assign bus.state      = state_q;
  assign bus.fare       = fare_q;
  assign bus.km_cnt     = km_q;
  assign bus.wait_units = wu_q;
  assign bus.meter_en   = meter_en_q;
  assign bus.meter_clr  = meter_clr_q;
  assign bus.trip_done  = done_q;

endmodule
